// File: rtl/object_stream_tx.sv
// Purpose: reads 8-bit pixels from the frame buffer in raster order and emits a thresholded 1-bit pixel stream with markers.
// Latency: pixel k appears on object_image two clocks after its address is issued (start edge E0 + 2 + k).
// Backpressure: none; the stream is gap-free. OBJECT_STREAM_CONTINUOUS_EN makes frames repeat back-to-back until reset.
module object_stream_tx #(
   parameter int IMAGE_WIDTH  = 160,
   parameter int IMAGE_HEIGHT = 120,
   parameter int ADDR_W       = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        threshold,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              object_image,
   output logic              pixel_valid,
   output logic              sof,
   output logic              eol,
   output logic              eof,
   output logic [7:0]        row,
   output logic [7:0]        col,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
   localparam logic [7:0]        COL_LAST  = 8'(IMAGE_WIDTH - 1);
   localparam logic [7:0]        ROW_LAST  = 8'(IMAGE_HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_start_acc;
   logic   w_issue_last;

   // Address stage: read strobe, linear address and the row/col of the address in flight.
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_row0;
   logic [7:0]        r_col0;

   // Memory stage: the pixel whose data arrives on mem_rd_data this cycle.
   logic              r_vld1;
   logic [7:0]        r_row1;
   logic [7:0]        r_col1;

   // Output stage.
   logic              r_obj;
   logic              r_pix_vld;
   logic              r_sof;
   logic              r_eol;
   logic              r_eof;
   logic [7:0]        r_row;
   logic [7:0]        r_col;
   logic              r_busy;
   logic              r_done;
   logic [7:0]        r_thr;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: accept start only when idle, leave STREAM once the final address is out,
   // and leave DRAIN on the cycle the last pixel (eof) sits on the outputs.
   always_comb begin
      w_state_nxt  = r_state;
      w_start_acc  = 1'b0;
      w_issue_last = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (r_addr == LAST_ADDR) begin
               w_issue_last = 1'b1;
`ifdef OBJECT_STREAM_CONTINUOUS_EN
               w_state_nxt  = S_STREAM;
`else
               w_state_nxt  = S_DRAIN;
`endif
            end
         end
         S_DRAIN: begin
            if (r_eof) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Address generator: one read per clock in raster order; the address holds at the last
   // pixel when the frame ends so it never leaves the frame buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_en <= 1'b0;
         r_addr  <= '0;
         r_row0  <= '0;
         r_col0  <= '0;
      end else if (w_start_acc) begin
         r_rd_en <= 1'b1;
         r_addr  <= '0;
         r_row0  <= '0;
         r_col0  <= '0;
      end else if (r_state == S_STREAM) begin
         if (w_issue_last) begin
`ifdef OBJECT_STREAM_CONTINUOUS_EN
            r_addr  <= '0;
            r_row0  <= '0;
            r_col0  <= '0;
`else
            r_rd_en <= 1'b0;
`endif
         end else begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_col0 == COL_LAST) begin
               r_col0 <= '0;
               r_row0 <= (r_row0 == ROW_LAST) ? 8'd0 : r_row0 + 8'd1;
            end else begin
               r_col0 <= r_col0 + 8'd1;
            end
         end
      end
   end

   // Memory stage: carry the coordinates alongside the outstanding read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld1 <= 1'b0;
         r_row1 <= '0;
         r_col1 <= '0;
      end else begin
         r_vld1 <= r_rd_en;
         r_row1 <= r_rd_en ? r_row0 : 8'd0;
         r_col1 <= r_rd_en ? r_col0 : 8'd0;
      end
   end

   // Output stage: threshold the returned data and derive markers; everything is zero between frames.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_obj     <= 1'b0;
         r_pix_vld <= 1'b0;
         r_sof     <= 1'b0;
         r_eol     <= 1'b0;
         r_eof     <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
      end else begin
         r_obj     <= r_vld1 && (mem_rd_data >= r_thr);
         r_pix_vld <= r_vld1;
         r_sof     <= r_vld1 && (r_row1 == 8'd0) && (r_col1 == 8'd0);
         r_eol     <= r_vld1 && (r_col1 == COL_LAST);
         r_eof     <= r_vld1 && (r_col1 == COL_LAST) && (r_row1 == ROW_LAST);
         r_row     <= r_vld1 ? r_row1 : 8'd0;
         r_col     <= r_vld1 ? r_col1 : 8'd0;
      end
   end

   // Frame control: threshold is captured only at an accepted start; done follows eof by one
   // clock, and busy drops on that same edge unless frames repeat continuously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_thr  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= r_eof;
         if (w_start_acc) begin
            r_thr  <= threshold;
            r_busy <= 1'b1;
         end
`ifndef OBJECT_STREAM_CONTINUOUS_EN
         else if (r_eof) begin
            r_busy <= 1'b0;
         end
`endif
      end
   end

   assign mem_rd_en    = r_rd_en;
   assign mem_addr     = r_addr;
   assign object_image = r_obj;
   assign pixel_valid  = r_pix_vld;
   assign sof          = r_sof;
   assign eol          = r_eol;
   assign eof          = r_eof;
   assign row          = r_row;
   assign col          = r_col;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_object_stream_tx.sv
// Bench for object_stream_tx: random and ramp frame-buffer contents, a frame-level reference
// model filling an expectation queue at each accepted start, and a monitor that pops and compares
// every emitted pixel plus done/busy/gap behaviour.
module tb_object_stream_tx;

   localparam int W    = 160;
   localparam int H    = 120;
   localparam int NPIX = W * H;
   localparam int AW   = 15;
`ifdef OBJECT_STREAM_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    threshold = 8'd0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rd_data = 8'd0;
   logic          object_image, pixel_valid, sof, eol, eof, busy, done;
   logic [7:0]    row, col;

   object_stream_tx #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .threshold(threshold),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .object_image(object_image), .pixel_valid(pixel_valid), .sof(sof), .eol(eol), .eof(eof),
      .row(row), .col(col), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame buffer: read data returns one clock after the strobe.
   logic [7:0] mem [NPIX];
   always @(posedge clk) begin
      if (mem_rd_en && int'(mem_addr) < NPIX) mem_rd_data <= mem[mem_addr];
      else                                    mem_rd_data <= 8'($urandom);
   end

   typedef struct packed {
      logic       pix;
      logic       sof;
      logic       eol;
      logic       eof;
      logic [7:0] row;
      logic [7:0] col;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   int          valid_cnt = 0;
   int          ones_cnt  = 0;
   int unsigned sof_cyc   = 0;
   int unsigned eof_cyc   = 0;
   int unsigned e0_cyc    = 0;
   bit          exp_done  = 1'b0;
   bit          in_frame  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a whole frame computed from the buffer contents and the threshold.
   task automatic push_frame(input logic [7:0] thr);
      exp_t r;
      for (int k = 0; k < NPIX; k++) begin
         r.pix = (mem[k] >= thr);
         r.row = 8'(k / W);
         r.col = 8'(k % W);
         r.sof = (k == 0);
         r.eol = ((k % W) == W - 1);
         r.eof = (k == NPIX - 1);
         expq.push_back(r);
      end
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < NPIX; k++) mem[k] = 8'(k);
   endtask

   task automatic fill_rand();
      for (int k = 0; k < NPIX; k++) mem[k] = 8'($urandom);
   endtask

   // Monitor: pops the expectation queue on every valid pixel.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         exp_done = 1'b0;
         in_frame = 1'b0;
      end else begin
         chk("done", done, exp_done);
         if (exp_done) chk("busy_at_done", busy, CONT);
         exp_done = 1'b0;
         if (mem_rd_en) chk("addr_range", (int'(mem_addr) < NPIX), 1);
         if (pixel_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_pixel", 1, 0);
               in_frame = 1'b0;
            end else begin
               e = expq.pop_front();
               chk($sformatf("pixel%0d", int'(e.row) * W + int'(e.col)),
                   {object_image, sof, eol, eof, row, col}, e);
               in_frame = !e.eof;
               exp_done = e.eof;
            end
            chk("busy_in_frame", busy, 1);
            if (sof) begin
               valid_cnt = 0;
               ones_cnt  = 0;
               sof_cyc   = cyc;
            end
            valid_cnt++;
            if (object_image) ones_cnt++;
            if (eof) eof_cyc = cyc;
         end else begin
            if (in_frame) chk("stream_gap", 0, 1);
            in_frame = 1'b0;
            chk("idle_markers", {sof, eol, eof, row, col}, 0);
         end
      end
   end

   task automatic start_frame(input logic [7:0] thr);
      int n = 0;
      @(negedge clk);
      while ((busy || done) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("wait_idle_timeout", 1, 0);
      valid_cnt = 0;
      sof_cyc   = 0;
      threshold = thr;
      start     = 1'b1;
      push_frame(thr);
      @(posedge clk);
      #1;
      e0_cyc    = cyc;
      start     = 1'b0;
      threshold = 8'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < NPIX + 100);
      if (!done) chk("done_timeout", 1, 0);
   endtask

   task automatic wait_pixels(input int cnt);
      int n = 0;
      while (valid_cnt < cnt && n < NPIX + 100) begin
         @(negedge clk);
         n++;
      end
      if (valid_cnt < cnt) chk("pixel_wait_timeout", valid_cnt, cnt);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned eof1;
      // Reset state and idling without start.
      repeat (3) @(negedge clk);
      chk("reset_outputs", {mem_rd_en, mem_addr, object_image, pixel_valid, sof, eol, eof,
                            row, col, busy, done}, 0);
      rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_no_read", {mem_rd_en, busy, pixel_valid, done}, 0);
      end

`ifdef OBJECT_STREAM_CONTINUOUS_EN
      // Back-to-back frames from a single start.
      fill_ramp();
      start_frame(8'd128);
      start = 1'b1;
      push_frame(8'd128);
      push_frame(8'd128);
      wait_done();
      eof1 = eof_cyc;
      chk("frame_valid_count", valid_cnt, NPIX);
      wait_done();
      chk("sof_after_eof", sof_cyc, eof1 + 1);
      chk("frame2_ones", ones_cnt, NPIX / 2);
      chk("busy_still_high", busy, 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("reset_stops", {mem_rd_en, pixel_valid, busy, done}, 0);
      expq.delete();
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
`else
      // Ramp frame at threshold 128; start then held high with a new threshold while busy.
      fill_ramp();
      start_frame(8'd128);
      start     = 1'b1;
      threshold = 8'd255;
      push_frame(8'd255);
      wait_done();
      eof1 = eof_cyc;
      chk("sof_latency_f1", sof_cyc - e0_cyc, 2);
      chk("valid_count_f1", valid_cnt, NPIX);
      chk("ones_f1", ones_cnt, 9600);
      @(posedge clk);
      #1 start = 1'b0;
      // Held-start restart with threshold 255: ones only where data is 255.
      wait_done();
      chk("restart_gap", sof_cyc, eof1 + 4);
      chk("valid_count_f2", valid_cnt, NPIX);
      chk("ones_thr255", ones_cnt, 75);

      // Start with a different threshold mid-frame must be ignored.
      fill_rand();
      start_frame(8'd200);
      wait_pixels(3000);
      @(negedge clk);
      start     = 1'b1;
      threshold = 8'd10;
      repeat (8) @(negedge clk);
      start = 1'b0;
      wait_done();
      chk("sof_latency_f3", sof_cyc - e0_cyc, 2);
      chk("valid_count_f3", valid_cnt, NPIX);

      // Asynchronous reset mid-frame, then a clean new frame at threshold 0.
      start_frame(8'($urandom));
      wait_pixels(5000);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("async_reset_outputs", {mem_rd_en, mem_addr, object_image, pixel_valid, sof, eol,
                                     eof, row, col, busy, done}, 0);
      expq.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_resume", {mem_rd_en, pixel_valid, busy}, 0);
      end
      start_frame(8'd0);
      wait_done();
      chk("sof_latency_f4", sof_cyc - e0_cyc, 2);
      chk("valid_count_f4", valid_cnt, NPIX);
      chk("ones_thr0", ones_cnt, NPIX);
`endif
      repeat (4) @(negedge clk);
      chk("queue_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
